// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder with a boot-load FSM; reads are combinational, writes land on the rising edge.
// Boot bytes are accepted on valid & ready; ready is high only while loading and drops once the image is complete.
module mips_mem_responder #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic        clock__i,
    input  logic        reset__i,
    input  logic [31:0] instrAddr__i,
    output logic [31:0] instrData__o,
    input  logic [31:0] memAddr__i,
    input  logic [31:0] memDataWrite__i,
    input  logic        memRead__i,
    input  logic        memWrite__i,
    output logic [31:0] memDataRead__o,
    input  logic        loadValid__i,
    input  logic [7:0]  loadByte__i,
    input  logic        loadLast__i,
    output logic        loadReady__o,
    output logic        coreReset_n__o,
    output logic        fault__o
);
    typedef enum logic {LOAD, RUN} state_t;

    state_t             state;
    logic [IMEM_AW-1:0] load_ptr;
    logic [1:0]         byte_cnt;
    logic [31:0]        asm_word;
    logic               ready_q;
    logic               run_q;
    logic               fault_q;

    logic [31:0] imem [2**IMEM_AW];
    logic [31:0] dmem [2**DMEM_AW];

    logic               accept;
    logic               word_done;
    logic               img_full;
    logic [31:0]        word_next;
    logic [IMEM_AW-1:0] iidx;
    logic [DMEM_AW-1:0] didx;
    logic               instr_ok;
    logic               data_ok;
    logic               instr_fault;
    logic               data_fault;

    // Both outputs drop during the reset cycle itself, before the state register is cleared.
    assign loadReady__o   = ready_q & ~reset__i;
    assign coreReset_n__o = run_q & ~reset__i;
    assign fault__o       = fault_q;

    assign accept    = loadValid__i & loadReady__o;
    assign word_done = accept & ((byte_cnt == 2'd3) | loadLast__i);
    assign img_full  = word_done & ~loadLast__i & (load_ptr == '1);

    always_comb begin
        word_next = asm_word;
        case (byte_cnt)
            2'd0:    word_next[31:24] = loadByte__i;
            2'd1:    word_next[23:16] = loadByte__i;
            2'd2:    word_next[15:8]  = loadByte__i;
            default: word_next[7:0]   = loadByte__i;
        endcase
    end

    assign iidx     = instrAddr__i[IMEM_AW+1:2];
    assign didx     = memAddr__i[DMEM_AW+1:2];
    assign instr_ok = (instrAddr__i[31:IMEM_AW+2] == '0) && (instrAddr__i[1:0] == 2'b00);
    assign data_ok  = (memAddr__i[31:DMEM_AW+2] == '0) && (memAddr__i[1:0] == 2'b00);

    // The fetch port is always live once the core runs, so a bad PC faults even without a strobe.
    assign instr_fault = (state == RUN) & ~instr_ok;
    assign data_fault  = (state == RUN) & (memRead__i | memWrite__i) & ~data_ok;

    assign instrData__o   = (state == RUN && instr_ok) ? imem[iidx] : '0;
    assign memDataRead__o = (state == RUN && memRead__i && data_ok) ? dmem[didx] : '0;

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            state    <= LOAD;
            load_ptr <= '0;
            byte_cnt <= 2'd0;
            asm_word <= '0;
            ready_q  <= 1'b1;
            run_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (word_done) begin
                        byte_cnt <= 2'd0;
                        asm_word <= '0;
                        load_ptr <= load_ptr + 1'b1;
                        if (loadLast__i || img_full) begin
                            state   <= RUN;
                            ready_q <= 1'b0;
                            run_q   <= 1'b1;
                        end
                        if (img_full) begin
                            fault_q <= 1'b1;
                        end
                    end else if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_word <= word_next;
                    end
                end
                default: begin
                    if (instr_fault || data_fault) begin
                        fault_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Arrays keep their contents across reset so a warm reset does not wipe memory.
    always_ff @(posedge clock__i) begin
        if (word_done) begin
            imem[load_ptr] <= word_next;
        end
    end

    always_ff @(posedge clock__i) begin
        if (!reset__i && state == RUN && memWrite__i && data_ok) begin
            dmem[didx] <= memDataWrite__i;
        end
    end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the 5-stage MIPS core's instruction and data ports, holding the instruction and data word arrays. After reset it runs a boot-load FSM. The FSM takes a byte stream over a valid/ready handshake, assembles big-endian words and writes them into instruction memory. Once loading is complete it releases the core from reset and serves fetches, loads and stores with zero-latency reads and clocked writes.

Parameters:
IMEM_AW, 8, log2 of instruction memory depth in 32-bit words (256 words)
DMEM_AW, 8, log2 of data memory depth in 32-bit words (256 words)

Ports:
clock__i  in  1  system clock; all state updates on rising edge
reset__i  in  1  synchronous, active-high reset
instrAddr__i  in  32  byte address of instruction fetch (core PC)
instrData__o  out  32  fetched instruction word (combinational)
memAddr__i  in  32  data memory byte address
memDataWrite__i  in  32  store data
memRead__i  in  1  load request
memWrite__i  in  1  store request
memDataRead__o  out  32  load data (combinational)
loadValid__i  in  1  boot byte valid
loadByte__i  in  8  boot byte
loadLast__i  in  1  qualifies final byte of image
loadReady__o  out  1  responder accepts boot byte this cycle
coreReset_n__o  out  1  active-low reset to core; low until load finishes
fault__o  out  1  sticky access fault flag

Behaviour:
- Only clock__i exists. Reset is synchronous and active-high.
- FSM states: LOAD, RUN.
- Reset (any cycle, including mid-load or mid-run):
  - state=LOAD, loadPtr=0, byteCnt=0, assembly reg=0, fault__o=0.
  - coreReset_n__o=0, loadReady__o=0 during the reset cycle.
  - Array contents are NOT cleared.
- LOAD state:
  - loadReady__o=1. A byte transfers when loadValid__i & loadReady__o.
  - Byte order is big-endian: byteCnt 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - On the 4th byte the full word is written to imem[loadPtr] at that edge, loadPtr increments and byteCnt goes to 0.
  - loadLast__i on an accepted byte: a partial word has its remaining low bytes zero-padded and is written. State then goes to RUN on the next cycle.
  - A write to loadPtr=2^IMEM_AW-1 with no loadLast__i means the image is too long. The FSM goes to RUN and sets fault__o. Later bytes are not accepted.
  - The data port is ignored: no writes, memDataRead__o=0. instrData__o=0 (NOP).
- RUN state:
  - loadReady__o=0 and coreReset_n__o=1, registered and asserted the first cycle in RUN.
  - RUN is held until reset__i.
- Instruction port (RUN only):
  - instrData__o = imem[instrAddr__i[IMEM_AW+1:2]].
  - Out-of-range (any bit above IMEM_AW+1 set) or misaligned (addr[1:0]!=0) returns 0 and sets fault__o.
- Data port (RUN only):
  - Word index is memAddr__i[DMEM_AW+1:2].
  - Read: memDataRead__o = memRead__i ? dmem[idx] : 0, combinational. This is sampled by the core's MEM/WB register the same cycle.
  - Write: when memWrite__i, dmem[idx] <= memDataWrite__i at the rising edge.
  - Read and write to the same address in the same cycle: the read returns the old value and the new value is visible next cycle.
  - Out-of-range or misaligned data access returns 0 and drops the write. fault__o is set on the next edge.
- fault__o is sticky until reset.
- No reads or writes outside the arrays.

Test Plan:
- Load image bytes 8C,01,00,04, AC,02,00,08 with loadLast__i on byte 8:
  - imem[0]=0x8C010004 and imem[1]=0xAC020008.
  - coreReset_n__o rises 1 cycle after the last byte; fault__o=0.
- Partial word: bytes 12,34,56 with last on 56 -> imem[0]=0x12345600, state RUN.
- RUN, memWrite__i=1, memAddr__i=0x10, data 0xDEADBEEF; same cycle memRead__i=1:
  - memDataRead__o equals the old dmem[4] that cycle.
  - Next cycle with memRead__i=1 it reads 0xDEADBEEF.
- Misaligned store at 0x13 and out-of-range load at 0x0000_0400 (DMEM_AW=8):
  - The store is dropped (dmem unchanged); the load returns 0.
  - fault__o=1 and stays 1.
- Oversize image: stream 1025 bytes with no loadLast__i (IMEM_AW=8):
  - After word 255 is written: RUN, fault__o=1, loadReady__o=0.
  - Byte 1025 is not accepted.
- Assert reset__i for 1 cycle mid-load (after 6 bytes):
  - Next cycle: LOAD, loadPtr=0, byteCnt=0, coreReset_n__o=0, fault__o=0.
  - Reloading 4 bytes overwrites imem[0]; imem[1] keeps its pre-reset value.
